ifft_frame_packer: RTL
======================

// Module: ifft_frame_packer
// PURPOSE
//  Upstream feeder for the 8-point IFFT core. Collects C_N_POINTS serial complex
//  bins (one bin per input beat) into one wide frame word. Drives the frame to the
//  IFFT core's s_axis port, with bin k at bits [64k+63:64k] (real upper, imag lower).
//  Checks frame alignment against tlast and counts framing errors.
// PARAMETERS
//  C_SAMPLE_WIDTH    64   bits per input bin: {real[63:32], imag[31:0]}, signed Q-format
//  C_N_POINTS        8    bins per frame; power of two, >=2
//  C_FRAME_WIDTH     512  C_SAMPLE_WIDTH*C_N_POINTS; output frame width
//  C_ERR_CNT_WIDTH   16   width of the saturating framing-error counter
// PORTS
//  s_axis_aclk     in   1               single clock for the whole block
//  s_axis_areset   in   1               synchronous reset, active-high
//  s_axis_tvalid   in   1               input bin valid
//  s_axis_tready   out  1               input bin accepted when tvalid&tready
//  s_axis_tdata    in   C_SAMPLE_WIDTH  one complex bin
//  s_axis_tlast    in   1               marks last bin of a frame
//  m_axis_tvalid   out  1               frame valid
//  m_axis_tready   in   1               IFFT core ready
//  m_axis_tdata    out  C_FRAME_WIDTH   packed frame, bin 0 at LSBs
//  m_axis_tlast    out  1               constant 1 (one beat = one frame)
//  err_runt        out  1               1-cycle pulse: tlast seen before bin N-1
//  err_no_last     out  1               1-cycle pulse: bin N-1 accepted without tlast
//  err_count       out  C_ERR_CNT_WIDTH saturating count of err_runt+err_no_last events
// BEHAVIOUR
//  Clocking/reset:
//  - One clock; reset is synchronous and active-high (s_axis_areset sampled on s_axis_aclk).
//  - Reset values: s_axis_tready=0 while reset high, m_axis_tvalid=0, m_axis_tdata=0,
//    err_runt=0, err_no_last=0, err_count=0, beat_cnt=0; collect buffer contents don't-care.
//  - Reset mid-frame discards the partial frame and any pending output frame.
//  State:
//  - beat_cnt (log2 N bits), collect buffer bins 0..N-2, output register + m_axis_tvalid.
//  Input handshake:
//  - s_axis_tready = !reset && !(beat_cnt==N-1 && m_axis_tvalid && !m_axis_tready).
//  - Bins 0..N-2 always accepted (buffer slot free), so stall occurs only on the closing bin.
//  - accept = s_axis_tvalid && s_axis_tready.
//  - accept, beat_cnt<N-1, tlast=0: buf[beat_cnt]<=tdata; beat_cnt++.
//  - accept, beat_cnt<N-1, tlast=1: runt. Bin dropped; beat_cnt<=0; err_runt pulses
//    next cycle; no frame emitted.
//  - accept, beat_cnt==N-1: m_axis_tdata<={tdata,buf[N-2],...,buf[0]}; m_axis_tvalid<=1;
//    beat_cnt<=0. If tlast=0, err_no_last pulses next cycle; the frame is still emitted
//    and the next bin starts a new frame.
//  Output:
//  - m_axis_tvalid clears on (m_axis_tvalid && m_axis_tready) unless a new frame loads
//    the same cycle; load+consume in one cycle keeps tvalid=1 with the new data.
//  - m_axis_tdata/tvalid are held stable while tvalid && !tready.
//  Latency and throughput:
//  - Closing bin accepted at edge N; m_axis_tvalid=1 from cycle N+1.
//  - Sustained rate 1 bin/clk with m_axis_tready=1; no bubbles between frames.
//  Errors:
//  - err_count adds 1 per error event and saturates at all-ones (no wrap).
//  - err_runt and err_no_last are mutually exclusive within a cycle.
// TESTING
//  - Reset, then 8 back-to-back bins tdata=k<<32|(k+100), tlast on k=7, m_tready=1
//    -> one frame 1 cycle after bin 7; bin k at [64k+63:64k]; errors 0.
//  - m_tready=0 with frame pending, then 8 more bins -> bins 0..6 accepted;
//    tready=0 on bin 7 until m_tready=1; second frame follows with no data loss.
//  - tlast on bin 3 -> err_runt pulse, err_count=1, no frame; next 8 bins with
//    tlast on 7 -> clean frame with those 8 bins.
//  - 8 bins with no tlast -> frame emitted, err_no_last pulse, err_count=1.
//  - Reset asserted after bin 4 with a frame stalled -> m_tvalid=0 and counter 0
//    next cycle; following 8-bin frame packed from bin 0.
//  - 2^16+5 runts -> err_count holds 16'hFFFF.

Source files
------------

// File: rtl/ifft_frame_packer.sv
// Collects C_N_POINTS serial complex bins into one wide frame for the IFFT core.
// Checks tlast alignment and keeps a saturating framing-error count.
module ifft_frame_packer #(
    parameter int unsigned C_SAMPLE_WIDTH  = 64,
    parameter int unsigned C_N_POINTS      = 8,
    parameter int unsigned C_FRAME_WIDTH   = C_SAMPLE_WIDTH * C_N_POINTS,
    parameter int unsigned C_ERR_CNT_WIDTH = 16
) (
    input  logic                       s_axis_aclk,
    input  logic                       s_axis_areset,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [C_SAMPLE_WIDTH-1:0]  s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [C_FRAME_WIDTH-1:0]   m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       err_runt,
    output logic                       err_no_last,
    output logic [C_ERR_CNT_WIDTH-1:0] err_count
);

    localparam int unsigned            CNT_W    = $clog2(C_N_POINTS);
    localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(C_N_POINTS - 1);

    logic [CNT_W-1:0]                           r_beat_cnt;
    logic [C_N_POINTS-2:0][C_SAMPLE_WIDTH-1:0]  r_buf;
    logic [C_FRAME_WIDTH-1:0]                   r_frame;
    logic                                       r_mvalid;
    logic                                       r_err_runt;
    logic                                       r_err_no_last;
    logic [C_ERR_CNT_WIDTH-1:0]                 r_err_count;

    logic w_last_beat;
    logic w_tready;
    logic w_accept;
    logic w_load;
    logic w_runt;
    logic w_no_last;

    // Only the closing bin can stall: earlier bins always have a free buffer slot.
    assign w_last_beat = (r_beat_cnt == LAST_IDX);
    assign w_tready    = !s_axis_areset && !(w_last_beat && r_mvalid && !m_axis_tready);
    assign w_accept    = s_axis_tvalid && w_tready;
    assign w_load      = w_accept && w_last_beat;
    assign w_runt      = w_accept && !w_last_beat && s_axis_tlast;
    assign w_no_last   = w_load && !s_axis_tlast;

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (w_last_beat || s_axis_tlast) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (w_accept && !w_last_beat && !s_axis_tlast) begin
            r_buf[r_beat_cnt] <= s_axis_tdata;
        end
    end

    // A load in the same cycle as a consume keeps tvalid high with the new frame.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_mvalid <= 1'b0;
            r_frame  <= '0;
        end else if (w_load) begin
            r_mvalid <= 1'b1;
            r_frame  <= {s_axis_tdata, r_buf};
        end else if (r_mvalid && m_axis_tready) begin
            r_mvalid <= 1'b0;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_err_runt    <= 1'b0;
            r_err_no_last <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_err_runt    <= w_runt;
            r_err_no_last <= w_no_last;
            if ((w_runt || w_no_last) && (r_err_count != '1)) begin
                r_err_count <= r_err_count + C_ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tvalid = r_mvalid;
    assign m_axis_tdata  = r_frame;
    assign m_axis_tlast  = 1'b1;
    assign err_runt      = r_err_runt;
    assign err_no_last   = r_err_no_last;
    assign err_count     = r_err_count;

endmodule
